pipelined_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder with carry-in/carry-out. It is the sequential successor to the team's 1-bit full adder.
- Operands are split into STAGES equal segments. Segment k is added in pipeline stage k, and its carry is registered into stage k+1.
- Valid/ready handshake on both sides. Throughput is 1 result per cycle; latency is STAGES cycles.
- Used as the wide accumulate/bias adder in the CNN accelerator datapath.

---
 rtl/pipelined_adder_pkg.sv | 23 ++
 rtl/pipelined_adder_if.sv | 46 ++++
 rtl/pipelined_adder_stage.sv | 99 +++++++++
 rtl/pipelined_adder.sv | 81 ++++++++
 tb/tb_pipelined_adder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipelined_adder_pkg
// Desc   : Default sizing, segment-width helper and parameter legality check
//          shared by the pipelined adder slice.
// Rev    : 1.0 - initial release
// ============================================================================
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    function automatic int seg_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 1;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module : pipelined_adder_if
// Desc   : Operand/result handshake bundle of the pipelined adder.
//          OVF exists only when PIPELINED_ADDER_OVF_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SUM;
    logic             Cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             OVF;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, SUM, Cout, OVF
    );
    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, SUM, Cout, OVF
    );
`else
    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, SUM, Cout
    );
    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, SUM, Cout
    );
`endif

endinterface
`default_nettype wire

// File: rtl/pipelined_adder_stage.sv
`default_nettype none
// ============================================================================
// Module : pipelined_adder_stage
// Desc   : One segment adder plus its valid/ready register slice.
//          Adds the dn_ovf port when PIPELINED_ADDER_OVF_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
module pipelined_adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG   = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic [WIDTH-1:0] up_sum,
    input  logic             up_carry,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_a,
    output logic [WIDTH-1:0] dn_b,
    output logic [WIDTH-1:0] dn_sum,
    output logic             dn_carry
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             dn_ovf
`endif
);

    localparam int LO = IDX * SEG;
    localparam int HI = LO + SEG - 1;

    logic [SEG:0]     w_seg;
    logic [WIDTH-1:0] w_sum_next;
    logic             r_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    assign w_seg = {1'b0, up_a[HI:LO]} + {1'b0, up_b[HI:LO]} + {{SEG{1'b0}}, up_carry};

    // Lower bits come from earlier stages; only this stage's segment is new.
    always_comb begin
        w_sum_next        = up_sum;
        w_sum_next[HI:LO] = w_seg[SEG-1:0];
    end

    assign up_ready = !r_valid || dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (up_ready) begin
            r_valid <= up_valid;
            if (up_valid) begin
                r_a     <= up_a;
                r_b     <= up_b;
                r_sum   <= w_sum_next;
                r_carry <= w_seg[SEG];
            end
        end
    end

    assign dn_valid = r_valid;
    assign dn_a     = r_a;
    assign dn_b     = r_b;
    assign dn_sum   = r_sum;
    assign dn_carry = r_carry;

`ifdef PIPELINED_ADDER_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Signed overflow judged on the top bit of this segment; meaningful in the last stage.
    assign w_ovf = (up_a[HI] == up_b[HI]) && (w_seg[SEG-1] != up_a[HI]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (up_ready && up_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign dn_ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module : pipelined_adder
// Desc   : STAGES-deep pipelined ripple-carry adder with valid/ready handshake.
//          Define PIPELINED_ADDER_OVF_EN to add the registered OVF output.
// Rev    : 1.0 - initial release
// ============================================================================
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_adder_if.slave   bus
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder: illegal WIDTH/STAGES combination");
    end

    // Index k is the input side of stage k; index STAGES is the output side.
    logic [STAGES:0]  w_valid;
    logic [STAGES:0]  w_ready;
    logic [STAGES:0]  w_carry;
    logic [WIDTH-1:0] w_a   [STAGES+1];
    logic [WIDTH-1:0] w_b   [STAGES+1];
    logic [WIDTH-1:0] w_sum [STAGES+1];

    assign w_valid[0]      = bus.in_valid;
    assign w_a[0]          = bus.A;
    assign w_b[0]          = bus.B;
    assign w_sum[0]        = '0;
    assign w_carry[0]      = bus.Cin;
    assign w_ready[STAGES] = bus.out_ready;

    assign bus.in_ready  = w_ready[0] && !rst;
    assign bus.out_valid = w_valid[STAGES];
    assign bus.SUM       = w_sum[STAGES];
    assign bus.Cout      = w_carry[STAGES];

`ifdef PIPELINED_ADDER_OVF_EN
    logic [STAGES-1:0] w_ovf;
    assign bus.OVF = w_ovf[STAGES-1];
    wire w_unused_skew = ^{w_a[STAGES], w_b[STAGES], w_ovf};
`else
    wire w_unused_skew = ^{w_a[STAGES], w_b[STAGES]};
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipelined_adder_stage #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (w_valid[k]),
            .up_ready (w_ready[k]),
            .up_a     (w_a[k]),
            .up_b     (w_b[k]),
            .up_sum   (w_sum[k]),
            .up_carry (w_carry[k]),
            .dn_valid (w_valid[k+1]),
            .dn_ready (w_ready[k+1]),
            .dn_a     (w_a[k+1]),
            .dn_b     (w_b[k+1]),
            .dn_sum   (w_sum[k+1]),
            .dn_carry (w_carry[k+1])
`ifdef PIPELINED_ADDER_OVF_EN
            ,
            .dn_ovf   (w_ovf[k])
`endif
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module : tb_pipelined_adder
// Desc   : Scoreboard bench for pipelined_adder (STAGES=4 main, 1 and 16 extra).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus   ();
    pipelined_adder_if #(.WIDTH(W)) bus1  ();
    pipelined_adder_if #(.WIDTH(W)) bus16 ();

    pipelined_adder #(.WIDTH(W), .STAGES(4))  dut    (.clk(clk), .rst(rst), .bus(bus));
    pipelined_adder #(.WIDTH(W), .STAGES(1))  dut_s1 (.clk(clk), .rst(rst), .bus(bus1));
    pipelined_adder #(.WIDTH(W), .STAGES(16)) dut_s16(.clk(clk), .rst(rst), .bus(bus16));

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed directed vectors: A, B, Cin -> SUM, Cout, OVF
    logic [W-1:0] d_a   [10] = '{16'hFFFF, 16'h1234, 16'h7FFF, 16'h8000, 16'h0000,
                                 16'hFFFF, 16'h00FF, 16'h0FFF, 16'h8000, 16'hAAAA};
    logic [W-1:0] d_b   [10] = '{16'h0001, 16'h4321, 16'h0001, 16'hFFFF, 16'h0000,
                                 16'hFFFF, 16'h0001, 16'h0000, 16'h8000, 16'h5555};
    logic         d_cin [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] d_sum [10] = '{16'h0000, 16'h5556, 16'h8000, 16'h7FFF, 16'h0001,
                                 16'hFFFF, 16'h0100, 16'h1000, 16'h0001, 16'hFFFF};
    logic         d_cout[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         d_ovf [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic exp_t hand(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return hand(t[W-1:0], t[W], (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]));
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input exp_t e);
        logic acc;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(e);
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL send_timeout in_ready=%b want=1", bus.in_ready);
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stray_output SUM=%h Cout=%b want=no_output", bus.SUM, bus.Cout);
            end else begin
                mon_e = exp_q.pop_front();
`ifdef PIPELINED_ADDER_OVF_EN
                chk("result_ovf_cout_sum", {bus.OVF, bus.Cout, bus.SUM},
                    {mon_e.ovf, mon_e.cout, mon_e.sum});
`else
                chk("result_cout_sum", {bus.Cout, bus.SUM}, {mon_e.cout, mon_e.sum});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, acc;
        logic [W:0]   held;
        int           lat, lat1, lat16, acc_cnt, t0;

        bus.in_valid   = 1'b0; bus.A   = '0; bus.B   = '0; bus.Cin   = 1'b0; bus.out_ready   = 1'b1;
        bus1.in_valid  = 1'b0; bus1.A  = '0; bus1.B  = '0; bus1.Cin  = 1'b0; bus1.out_ready  = 1'b1;
        bus16.in_valid = 1'b0; bus16.A = '0; bus16.B = '0; bus16.Cin = 1'b0; bus16.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.SUM, 0);
        chk("rst_cout", bus.Cout, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        #1 rst = 1'b0;
        #1 chk("in_ready_after_rst", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // First vector: measure accept-to-output latency
        send(d_a[0], d_b[0], d_cin[0], hand(d_sum[0], d_cout[0], d_ovf[0]));
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency_s4", lat, 4);
        drain("drain_first");

        // Back-to-back directed then random stream, one accept per cycle
        t0 = cyc;
        for (int i = 1; i < 10; i++)
            send(d_a[i], d_b[i], d_cin[i], hand(d_sum[i], d_cout[i], d_ovf[i]));
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            send(ra, rb, rc, model(ra, rb, rc));
        end
        chk("stream_cycles", cyc - t0, 49);
        bus.in_valid = 1'b0;
        drain("drain_stream");

        // Backpressure: six offers, only four fit
        bus.out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            ra = 16'(i * 16'h1111);
            rb = 16'h0F0F;
            rc = 1'(i);
            bus.A = ra; bus.B = rb; bus.Cin = rc; bus.in_valid = 1'b1;
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(model(ra, rb, rc));
                acc_cnt++;
            end
        end
        bus.in_valid = 1'b0;
        chk("bp_accepts", acc_cnt, 4);
        @(negedge clk);
        held = {bus.Cout, bus.SUM};
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_head_value", held, 17'h00F0F);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", {bus.Cout, bus.SUM}, held);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain("bp_drain");

        // Reset with three transactions in flight
        repeat (2) @(posedge clk);
        #1;
        send(16'h1111, 16'h2222, 1'b0, hand(16'h3333, 1'b0, 1'b0));
        send(16'h0001, 16'h0002, 1'b1, hand(16'h0004, 1'b0, 1'b0));
        send(16'hF000, 16'h1000, 1'b0, hand(16'h0000, 1'b1, 1'b0));
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", bus.out_valid, 1);
        chk("pre_rst_sum", bus.SUM, 16'h3333);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_sum", bus.SUM, 0);
        chk("async_rst_cout", bus.Cout, 0);
        chk("async_rst_in_ready", bus.in_ready, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("in_ready_after_mid_rst", bus.in_ready, 1);
        repeat (12) @(posedge clk);
        #1;

        // STAGES=1 and STAGES=16 instances
        bus1.A  = 16'h8000; bus1.B  = 16'h8000; bus1.Cin  = 1'b1; bus1.in_valid  = 1'b1;
        bus16.A = 16'h8000; bus16.B = 16'h8000; bus16.Cin = 1'b1; bus16.in_valid = 1'b1;
        @(negedge clk);
        chk("s1_in_ready", bus1.in_ready, 1);
        chk("s16_in_ready", bus16.in_ready, 1);
        @(posedge clk);
        #1;
        bus1.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        lat1  = 0;
        lat16 = 0;
        for (int n = 1; n <= 40; n++) begin
            if (lat1 == 0 && bus1.out_valid) begin
                lat1 = n;
                chk("s1_result", {bus1.Cout, bus1.SUM}, 17'h10001);
            end
            if (lat16 == 0 && bus16.out_valid) begin
                lat16 = n;
                chk("s16_result", {bus16.Cout, bus16.SUM}, 17'h10001);
            end
            @(posedge clk);
            #1;
        end
        chk("latency_s1", lat1, 1);
        chk("latency_s16", lat16, 16);

        chk("queue_empty_at_end", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
